// File: rtl/md_pkg.sv
// Shared encodings, FSM state type and default latencies for the
// multiply/divide sequencer.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int MD_MUL_LAT_DEF = 5;
    localparam int MD_DIV_LAT_DEF = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Ops that occupy the unit and later commit to HI/LO.
    function automatic logic md_is_arith(input logic [2:0] op);
        return (op <= MD_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational MULT/MULTU/DIV/DIVU datapath. Produces the HI/LO pair the
// sequencer latches at issue, plus a divide-by-zero flag.
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_div0
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_signed_div;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_divisor;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    // Signed divide runs on magnitudes; 0x80000000 has magnitude 0x80000000,
    // so MIN/-1 falls out as quotient 0x80000000, remainder 0.
    assign w_signed_div = (i_op == MD_DIV);
    assign w_neg_a      = w_signed_div & i_a[31];
    assign w_neg_b      = w_signed_div & i_b[31];
    assign w_mag_a      = w_neg_a ? -i_a : i_a;
    assign w_divisor    = (i_b == 32'd0) ? 32'd1 : (w_neg_b ? -i_b : i_b);
    assign w_quot       = w_mag_a / w_divisor;
    assign w_rem        = w_mag_a % w_divisor;

    always_comb begin
        o_hi   = 32'd0;
        o_lo   = 32'd0;
        o_div0 = 1'b0;
        case (i_op)
            MD_MULT:  {o_hi, o_lo} = w_prod_s;
            MD_MULTU: {o_hi, o_lo} = w_prod_u;
            MD_DIV, MD_DIVU: begin
                o_div0 = (i_b == 32'd0);
                o_lo   = (w_neg_a ^ w_neg_b) ? -w_quot : w_quot;
                o_hi   = w_neg_a ? -w_rem : w_rem;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer: computes at issue, holds busy for a fixed
// latency, then commits to HI/LO. Drives the D-stage MD hazard stall.
module md_ctrl
    import md_pkg::*;
#(
    parameter int MUL_LAT = MD_MUL_LAT_DEF,
    parameter int DIV_LAT = MD_DIV_LAT_DEF,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        E_start,
    input  logic [2:0]  E_op,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_md_use,
    input  logic        abort,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output md_state_e   dbg_state
);

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    md_state_e        r_state;
    md_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_pend_hi;
    logic [31:0]      r_pend_lo;
    logic             r_pend_ok;
    logic [31:0]      w_ar_hi;
    logic [31:0]      w_ar_lo;
    logic             w_ar_div0;
    logic             w_start;
    logic             w_commit;
    logic             w_dec;
    logic             w_wr_hi;
    logic             w_wr_lo;

    md_arith u_arith (
        .i_op   (E_op),
        .i_a    (E_A),
        .i_b    (E_B),
        .o_hi   (w_ar_hi),
        .o_lo   (w_ar_lo),
        .o_div0 (w_ar_div0)
    );

    // Issue protocol: E_start is a one-cycle strobe with no ready; it is
    // taken only in IDLE without abort, and the hazard unit uses stall to
    // keep a second MD op out of E while busy.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_commit    = 1'b0;
        w_dec       = 1'b0;
        w_wr_hi     = 1'b0;
        w_wr_lo     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (E_start && !abort) begin
                    if (md_is_arith(E_op)) begin
                        w_start     = 1'b1;
                        w_state_nxt = ST_RUN;
                    end else if (E_op == MD_MTHI) begin
                        w_wr_hi = 1'b1;
                    end else if (E_op == MD_MTLO) begin
                        w_wr_lo = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == '0) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_ok <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_cnt     <= E_op[1] ? DIV_CNT : MUL_CNT;
                r_pend_hi <= w_ar_hi;
                r_pend_lo <= w_ar_lo;
                r_pend_ok <= !w_ar_div0;
            end else if (w_dec) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            // A divide by zero still runs its full latency but leaves HI/LO alone.
            if (w_commit && r_pend_ok) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
            if (w_wr_hi) r_hi <= E_A;
            if (w_wr_lo) r_lo <= E_A;
        end
    end

    assign busy      = (r_state == ST_RUN);
    assign stall     = D_md_use & (busy | (E_start & md_is_arith(E_op)));
    assign HI        = r_hi;
    assign LO        = r_lo;
    assign dbg_state = r_state;

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Sequencer for the multiply/divide unit and the HI/LO register pair in the 5-stage MIPS pipeline.
- Accepts MD ops issued from E stage and computes the result at issue.
- Holds the unit busy for a fixed op latency, then commits to HI/LO.
- Raises the D-stage stall the hazard logic needs while an MD-dependent instruction waits in D; supports abort on pipeline flush.

Parameters:
- MUL_LAT, 5, cycles busy for MULT/MULTU (must be >= 1)
- DIV_LAT, 10, cycles busy for DIV/DIVU (must be >= 1)
- CNT_W, 4, counter width; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT)

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- E_start  input  1  valid MD op in E this cycle
- E_op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 reserved (no-op)
- E_A  input  32  rs operand (forwarded)
- E_B  input  32  rt operand (forwarded)
- D_md_use  input  1  D-stage instr is MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO
- abort  input  1  flush of in-flight MD op (exception/eret)
- busy  output  1  op in progress
- stall  output  1  = D_md_use & (busy | (E_start & E_op<=3))
- HI  output  32  architectural HI
- LO  output  32  architectural LO

Behaviour:
- Reset (async, reset_n=0): state=IDLE, cnt=0, HI=0, LO=0, pend_hi=pend_lo=0, busy=0. A reset asserted mid-operation discards the pending result.
- States: IDLE, RUN. busy = (state==RUN), registered.
- IDLE, E_start & E_op in {0..3} & !abort at edge t0:
  - Latch pend_hi/pend_lo from the combinational result.
  - cnt <= LAT-1 (LAT = MUL_LAT or DIV_LAT); state <= RUN.
  - busy is high for cycles t0+1 .. t0+LAT.
- RUN, each edge:
  - If abort: state <= IDLE; HI/LO unchanged; pending result dropped.
  - Else if cnt==0: HI <= pend_hi, LO <= pend_lo, state <= IDLE. busy falls and HI/LO update on the same edge t0+LAT.
  - Else: cnt <= cnt-1.
- MTHI/MTLO: in IDLE with E_start & !abort, HI (or LO) <= E_A at the next edge; no busy cycle.
- Reserved E_op values: ignored.
- E_start while RUN: ignored, with no state change. Hazard logic prevents this via stall; the bench treats it as an error.
- abort with E_start in IDLE: start ignored; abort wins over everything, including the final RUN cycle.
- Arithmetic:
  - MULT: signed 64-bit product {HI,LO}. MULTU: unsigned product.
  - DIV: LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
  - DIVU: unsigned quotient/remainder.
  - Divide by zero: full DIV_LAT busy, then HI/LO unchanged.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- stall is combinational from registered busy plus the E_start/E_op/D_md_use inputs. MFHI/MFLO read HI/LO directly; with no stall active they see committed values.

Decomposition:
- Package md_pkg: E_op encodings (MD_MULT..MD_MTLO), state enum (IDLE, RUN), default latencies.
- Sub-module md_arith: purely combinational (op, a, b) -> {hi, lo, div0}. Contains all signed/unsigned mul/div rules, including both boundary cases.
- md_ctrl: holds the FSM, counter, pending/architectural registers and stall.

Test Plan:
- Reset mid-RUN:
  - Start MULT, assert reset_n=0 at cycle 2 -> busy=0, HI=LO=0 immediately.
  - After release, stays IDLE.
- MULT:
  - E_A=0xFFFFFFFE (-2), E_B=3 at t0 -> busy high exactly cycles t0+1..t0+5.
  - At edge t0+5: HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV:
  - E_A=-7 (0xFFFFFFF9), E_B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
  - DIVU 7/0 -> 10 busy cycles, HI/LO retain prior values.
- Stall:
  - D_md_use=1 (MFLO) with E_start MULT -> stall=1 from the issue cycle through the last busy cycle (6 cycles).
  - stall=0 the cycle busy falls; MFLO then reads the new LO.
- Abort:
  - Start DIV, abort at the 4th busy cycle -> busy=0 next edge, HI/LO unchanged.
  - abort coincident with cnt==0 -> no commit.
  - abort with E_start in IDLE -> no start.
- MTHI/MTLO:
  - MTHI E_A=0x12345678 in IDLE -> HI=0x12345678 next edge, busy stays 0.
  - E_start MULT while RUN -> ignored, original result commits on schedule.
